ctrlr_if: RTL and testbench
===========================

# ctrlr_if

Game-controller responder for the memory controller's controller read port. It autonomously scans two serial-shift (NES-style) gamepads at a fixed poll rate. It holds the latest button states in registers and returns them on `din_ctrlrs` when the memory controller asserts `ctrlr_re` with a 2-bit register address. It sits beside `mem_ctrl` and drives the pad latch and clock pins on the breakout board.

## Interface
- `HALF_DIV`, 300: clk cycles per pad half-period; must be >= 4.
- `POLL_PERIOD`, 833333: clk cycles between scan starts; must be > 16*`HALF_DIV`.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `ctrlr_re`  in  1  read enable from `mem_ctrl`.
- `addr_ctrlr`  in  2  register select from `mem_ctrl`.
- `din_ctrlrs`  out  16  read data to `mem_ctrl`.
- `pad_latch`  out  1  latch strobe to both pads, active-high.
- `pad_clk`  out  1  shift clock to both pads; idles high.
- `pad_data0`  in  1  serial data from pad 0; active-low button, asynchronous.
- `pad_data1`  in  1  serial data from pad 1; active-low button, asynchronous.

## Operation
- Each `pad_dataN` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Register map (`addr_ctrlr`):
  - 0 = {8'h00, btn0}
  - 1 = {8'h00, btn1}
  - 2 = {13'h0, busy, new1, new0}
  - 3 = scan_count (16-bit, wraps FFFF->0000)
- Button bit order, bit0..bit7: A, B, Select, Start, Up, Down, Left, Right. Registers are active-high: pressed = 1, which is the inverse of pad data.
- `din_ctrlrs` is combinational from registered state.
  - Equals the selected register while `ctrlr_re`=1.
  - Equals 16'h0000 while `ctrlr_re`=0.
- Read side effect: a rising edge with `ctrlr_re`=1 and `addr_ctrlr`=2 clears `new0` and `new1` after returning their old values. Reads of other addresses have no side effect.
- Poll counter runs free from 0 to `POLL_PERIOD`-1 and wraps. The FSM leaves IDLE on the cycle the counter equals `POLL_PERIOD`-1.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE. A bit index k (0..7) tracks position in the scan.
  - IDLE: `pad_latch`=0, `pad_clk`=1, busy=0.
  - LATCH: `pad_latch`=1 for `HALF_DIV` cycles. On the last cycle, sample bit 0 from both pads, set k=1, go to LOW.
  - LOW: `pad_clk`=0 for `HALF_DIV` cycles, then go to HIGH.
  - HIGH: `pad_clk`=1 for `HALF_DIV` cycles. On the last cycle, sample bit k. If k=7 go to DONE; otherwise k++ and go to LOW.
  - DONE: one cycle.
    - Commit the inverted shift registers to btn0 and btn1.
    - Set `newN`=1 if the committed value differs from the previous btnN.
    - Increment scan_count.
    - Return to IDLE.
- busy=1 in every state except IDLE.
- A clear-by-read of addr 2 on the same edge as DONE sets a flag: set wins for that flag.
- btn0, btn1 and scan_count change only in DONE. A partially shifted scan never becomes visible.

## Timing
- Reset values:
  - `pad_latch`=0, `pad_clk`=1, `din_ctrlrs`=0.
  - btn0 = btn1 = 8'h00, `new0` = `new1` = 0, scan_count=0.
  - State=IDLE, poll counter=0, k=0.
- Reset asserted mid-scan aborts immediately to the reset values. The first scan after release starts when the poll counter reaches `POLL_PERIOD`-1.
- Scan length: `HALF_DIV` + 14*`HALF_DIV` + 1 = 15*`HALF_DIV`+1 cycles from entering LATCH to returning to IDLE.
- `pad_latch` pulse: exactly `HALF_DIV` cycles. Exactly 7 `pad_clk` low pulses per scan, each `HALF_DIV` cycles low.
- Pad-to-register latency: a pad level must be stable at the synchronizer input at least 2 cycles before its sample cycle.
- Read latency is zero: data is valid in the same cycle as `ctrlr_re`.

## Test plan
All scenarios use `HALF_DIV`=4 and `POLL_PERIOD`=100.
- Reset then idle: hold `rst`=0, release, read all 4 addresses with `pad_dataN`=1.
  - Before the first scan: 0x0000 everywhere.
  - After the first DONE: addr3=0x0001, new flags=0.
- Pattern capture: pad model returns A and Start pressed on pad0, and Right pressed on pad1.
  - After DONE: addr0=0x0009, addr1=0x0080, addr2=0x0003.
  - Reading addr2 again returns 0x0000.
- Pin timing: check waveforms over one scan.
  - `pad_latch` high exactly 4 cycles.
  - 7 `pad_clk` low pulses of 4 cycles each.
  - Total busy = 61 cycles.
  - Scan starts recur every 100 cycles.
- Unchanged data: two consecutive scans with identical pad data. The second scan leaves new0 = new1 = 0 and scan_count increments.
- Collision: read addr2 with `ctrlr_re`=1 on the exact DONE edge of a changing scan. The read returns the old flags and the flags remain set afterward.
- Reset mid-scan: assert `rst` during the LOW phase of bit 4.
  - `pad_clk`=1 and `pad_latch`=0 at once.
  - btn registers read 0x0000.
  - No DONE occurs until the next poll.

Source files
------------

// File: rtl/ctrlr_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrlr_if
// Description : Scans two NES-style serial gamepads at a fixed poll rate and
//               serves the latest button states, change flags and a scan
//               counter to the memory controller's read port.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrlr_if #(
    parameter int HALF_DIV    = 300,
    parameter int POLL_PERIOD = 833333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrlr_re,
    input  logic [1:0]  addr_ctrlr,
    output logic [15:0] din_ctrlrs,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic        pad_data0,
    input  logic        pad_data1
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [1:0]    sync0;
    logic [1:0]    sync1;
    logic [PW-1:0] poll_cnt;
    logic [DW-1:0] div_cnt;
    logic [2:0]    k;
    logic [7:0]    sh0;
    logic [7:0]    sh1;
    logic [7:0]    btn0;
    logic [7:0]    btn1;
    logic          new0;
    logic          new1;
    logic [15:0]   scan_count;

    logic d0;
    logic d1;
    logic busy;
    logic poll_hit;
    logic div_last;
    logic clear_req;

    assign d0        = sync0[1];
    assign d1        = sync1[1];
    assign busy      = (state != IDLE);
    assign poll_hit  = (poll_cnt == POLL_LAST);
    assign div_last  = (div_cnt == DIV_LAST);
    assign clear_req = ctrlr_re && (addr_ctrlr == 2'd2);

    // Two-flop synchronizers for the asynchronous pad data lines (idle high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0 <= 2'b11;
            sync1 <= 2'b11;
        end else begin
            sync0 <= {sync0[0], pad_data0};
            sync1 <= {sync1[0], pad_data1};
        end
    end

    // Free-running poll counter; a scan starts each time it reaches its top
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt <= '0;
        end else if (poll_hit) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // Scan sequencer: pad pins, shift capture, commit of buttons and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            k          <= 3'd0;
            pad_latch  <= 1'b0;
            pad_clk    <= 1'b1;
            sh0        <= 8'h00;
            sh1        <= 8'h00;
            btn0       <= 8'h00;
            btn1       <= 8'h00;
            new0       <= 1'b0;
            new1       <= 1'b0;
            scan_count <= 16'h0000;
        end else begin
            // Read-to-clear; a commit later in this block overrides it
            if (clear_req) begin
                new0 <= 1'b0;
                new1 <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (poll_hit) begin
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                        div_cnt   <= '0;
                    end
                end
                LATCH: begin
                    if (div_last) begin
                        sh0[0]    <= d0;
                        sh1[0]    <= d1;
                        k         <= 3'd1;
                        div_cnt   <= '0;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                        state     <= LOW;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        pad_clk <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_last) begin
                        sh0[k]  <= d0;
                        sh1[k]  <= d1;
                        div_cnt <= '0;
                        if (k == 3'd7) begin
                            state <= DONE;
                        end else begin
                            k       <= k + 3'd1;
                            pad_clk <= 1'b0;
                            state   <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    btn0       <= ~sh0;
                    btn1       <= ~sh1;
                    scan_count <= scan_count + 16'd1;
                    if (~sh0 != btn0) begin
                        new0 <= 1'b1;
                    end
                    if (~sh1 != btn1) begin
                        new1 <= 1'b1;
                    end
                    k     <= 3'd0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Zero-latency read mux; bus is driven to zero when not selected
    always_comb begin
        din_ctrlrs = 16'h0000;
        if (ctrlr_re) begin
            case (addr_ctrlr)
                2'd0:    din_ctrlrs = {8'h00, btn0};
                2'd1:    din_ctrlrs = {8'h00, btn1};
                2'd2:    din_ctrlrs = {13'h0000, busy, new1, new0};
                default: din_ctrlrs = scan_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrlr_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrlr_if
// Description : Randomized self-checking bench for ctrlr_if with a serial
//               gamepad model and a cycle-indexed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrlr_if;

    localparam int HALF_DIV    = 4;
    localparam int POLL_PERIOD = 100;
    localparam int SCAN_LEN    = 15 * HALF_DIV + 1;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        ctrlr_re   = 1'b0;
    logic [1:0]  addr_ctrlr = 2'd0;
    logic [15:0] din_ctrlrs;
    logic        pad_latch;
    logic        pad_clk;
    logic        pad_data0;
    logic        pad_data1;

    // Buttons held on each pad (pressed = 1) and the pads' internal shifters
    logic [7:0] btns0 = 8'h00;
    logic [7:0] btns1 = 8'h00;
    logic [7:0] psh0  = 8'h00;
    logic [7:0] psh1  = 8'h00;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;   // clock edges since reset release

    // Reference model state
    logic [7:0]  m_btn0 = 8'h00;
    logic [7:0]  m_btn1 = 8'h00;
    logic [7:0]  lat0   = 8'h00;
    logic [7:0]  lat1   = 8'h00;
    logic        m_new0 = 1'b0;
    logic        m_new1 = 1'b0;
    logic [15:0] m_cnt  = 16'h0000;

    always #5 clk = ~clk;

    ctrlr_if #(
        .HALF_DIV    (HALF_DIV),
        .POLL_PERIOD (POLL_PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrlr_re   (ctrlr_re),
        .addr_ctrlr (addr_ctrlr),
        .din_ctrlrs (din_ctrlrs),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .pad_data0  (pad_data0),
        .pad_data1  (pad_data1)
    );

    // NES pad: parallel load on latch, shift on each rising clock, active-low out
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) begin
            psh0 <= btns0;
            psh1 <= btns1;
        end else begin
            psh0 <= psh0 >> 1;
            psh1 <= psh1 >> 1;
        end
    end
    assign pad_data0 = ~psh0[0];
    assign pad_data1 = ~psh1[0];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // Scan window: starts on every poll edge after the first period
    function automatic logic exp_busy(input int c);
        return (c >= POLL_PERIOD) && ((c % POLL_PERIOD) < SCAN_LEN);
    endfunction

    function automatic logic exp_latch(input int c);
        return (c >= POLL_PERIOD) && ((c % POLL_PERIOD) < HALF_DIV);
    endfunction

    function automatic logic exp_clk(input int c);
        int p;
        p = (c % POLL_PERIOD) - HALF_DIV;
        if (c < POLL_PERIOD || p < 0 || p >= 14 * HALF_DIV) return 1'b1;
        return ((p / HALF_DIV) % 2) != 0;
    endfunction

    function automatic logic [15:0] exp_rd(input logic re, input logic [1:0] a);
        if (!re) return 16'h0000;
        case (a)
            2'd0:    return {8'h00, m_btn0};
            2'd1:    return {8'h00, m_btn1};
            2'd2:    return {13'h0000, exp_busy(n), m_new1, m_new0};
            default: return m_cnt;
        endcase
    endfunction

    // One clock: drive read port, check outputs, advance DUT and model
    task automatic step(input logic re, input logic [1:0] a);
        ctrlr_re   = re;
        addr_ctrlr = a;
        #1;
        chk("din", din_ctrlrs, exp_rd(re, a));
        chk("pad_latch", {15'd0, pad_latch}, {15'd0, exp_latch(n)});
        chk("pad_clk", {15'd0, pad_clk}, {15'd0, exp_clk(n)});
        @(posedge clk);
        n++;
        if (n >= POLL_PERIOD && (n % POLL_PERIOD) == 0) begin
            lat0 = btns0;
            lat1 = btns1;
        end
        if (re && a == 2'd2) begin
            m_new0 = 1'b0;
            m_new1 = 1'b0;
        end
        if (n > POLL_PERIOD && (n % POLL_PERIOD) == SCAN_LEN) begin
            if (lat0 != m_btn0) m_new0 = 1'b1;
            if (lat1 != m_btn1) m_new1 = 1'b1;
            m_btn0 = lat0;
            m_btn1 = lat1;
            m_cnt  = m_cnt + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic run_to(input int target, input bit allow_clr, input bit churn);
        while (n < target) begin
            logic [1:0] a;
            if (churn && $urandom_range(0, 39) == 0) begin
                btns0 = 8'($urandom);
                btns1 = 8'($urandom);
            end
            a = 2'($urandom_range(0, 3));
            if (!allow_clr && a == 2'd2) a = 2'd3;
            step(1'($urandom_range(0, 1)), a);
        end
    endtask

    task automatic rd_expect(input string tag, input logic [1:0] a, input logic [15:0] exp);
        ctrlr_re   = 1'b1;
        addr_ctrlr = a;
        #1;
        chk(tag, din_ctrlrs, exp);
    endtask

    // Assert reset (asynchronously), check reset outputs, release on a negedge
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_latch", {15'd0, pad_latch}, 16'h0000);
        chk("rst_clk", {15'd0, pad_clk}, 16'h0001);
        for (int a = 0; a < 4; a++) begin
            ctrlr_re   = 1'b1;
            addr_ctrlr = 2'(a);
            #1;
            chk("rst_rd", din_ctrlrs, 16'h0000);
        end
        ctrlr_re = 1'b0;
        #1;
        chk("rst_din_idle", din_ctrlrs, 16'h0000);
        m_btn0 = 8'h00;
        m_btn1 = 8'h00;
        m_new0 = 1'b0;
        m_new1 = 1'b0;
        m_cnt  = 16'h0000;
        n      = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Idle pads: nothing before the first scan, count 1 after it
        run_to(99, 1'b1, 1'b0);
        rd_expect("pre_scan_a3", 2'd3, 16'h0000);
        run_to(SCAN_LEN + POLL_PERIOD, 1'b1, 1'b0);
        rd_expect("first_a3", 2'd3, 16'h0001);
        rd_expect("first_a2", 2'd2, 16'h0000);

        // Pattern capture: pad0 A+Start, pad1 Right
        btns0 = 8'h09;
        btns1 = 8'h80;
        run_to(2 * POLL_PERIOD + SCAN_LEN, 1'b0, 1'b0);
        rd_expect("pat_a0", 2'd0, 16'h0009);
        rd_expect("pat_a1", 2'd1, 16'h0080);
        rd_expect("pat_a2", 2'd2, 16'h0003);
        step(1'b1, 2'd2);
        rd_expect("pat_a2_cleared", 2'd2, 16'h0000);

        // Unchanged data: no flags, counter still advances
        run_to(3 * POLL_PERIOD + SCAN_LEN, 1'b1, 1'b0);
        rd_expect("same_a2", 2'd2, 16'h0000);
        rd_expect("same_a3", 2'd3, 16'h0003);

        // Collision: clear-by-read on the commit edge of a changing scan
        btns0 = 8'h5A;
        btns1 = 8'h3C;
        run_to(4 * POLL_PERIOD + SCAN_LEN - 1, 1'b0, 1'b0);
        rd_expect("coll_old", 2'd2, 16'h0004);
        step(1'b1, 2'd2);
        rd_expect("coll_after", 2'd2, 16'h0003);
        rd_expect("coll_a0", 2'd0, 16'h005A);

        // Random pad data and random reads over several scans
        run_to(14 * POLL_PERIOD, 1'b1, 1'b1);

        // Reset during the LOW phase of bit 4, then no commit until next poll
        run_to(14 * POLL_PERIOD + HALF_DIV + 6 * HALF_DIV + 1, 1'b1, 1'b0);
        chk("mid_clk_low", {15'd0, pad_clk}, 16'h0000);
        do_reset();
        run_to(POLL_PERIOD + SCAN_LEN - 1, 1'b1, 1'b0);
        rd_expect("post_rst_a3", 2'd3, 16'h0000);
        rd_expect("post_rst_a0", 2'd0, 16'h0000);
        step(1'b0, 2'd0);
        rd_expect("post_rst_scan", 2'd3, 16'h0001);
        run_to(2 * POLL_PERIOD + 10, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
